// File: rtl/recip_interp_if.sv
// recip_interp_if: handshake and coefficient-table bundle for recip_interp.
//   in_valid/in_ready/in_mant    : operand handshake (mantissa source side)
//   tbl_idx -> tbl_base/fd/sd    : coefficient table lookup (combinational table)
//   out_valid/out_ready/out_recip: result handshake (reciprocal datapath side)
// slave  : the evaluator (recip_interp)
// master : whatever drives operands, the table, and consumes results
interface recip_interp_if;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] in_mant;
  logic [6:0]  tbl_idx;
  logic [26:0] tbl_base;
  logic [17:0] tbl_fd;
  logic [10:0] tbl_sd;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] out_recip;

  modport slave (
    input  in_valid, in_mant, tbl_base, tbl_fd, tbl_sd, out_ready,
    output in_ready, tbl_idx, out_valid, out_recip
  );

  modport master (
    output in_valid, in_mant, tbl_base, tbl_fd, tbl_sd, out_ready,
    input  in_ready, tbl_idx, out_valid, out_recip
  );
endinterface

// File: rtl/recip_interp.sv
// recip_interp: sequential piecewise-quadratic reciprocal evaluator.
// Computes clamp(base - fd*f + sd*f^2) over four states using one shared
// 18x16 unsigned multiplier, with coefficients fetched from an external
// combinational table addressed by the registered index.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : recip_interp_if.slave (operand, table and result handshakes)
module recip_interp (
  input  logic               clk,
  input  logic               rst,
  recip_interp_if.slave      bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOOK = 3'd1,
    FD   = 3'd2,
    SD   = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         idx_q,   idx_d;
  logic [15:0]        f_q,     f_d;
  logic [26:0]        base_q,  base_d;
  logic [17:0]        fd_q,    fd_d;
  logic [10:0]        sd_q,    sd_d;
  logic [15:0]        sq_q,    sq_d;
  logic [18:0]        t1_q,    t1_d;
  logic [11:0]        t2_q,    t2_d;
  logic signed [28:0] acc_q,   acc_d;

  // Shared multiplier operands, selected by state.
  logic [17:0] mul_a;
  logic [15:0] mul_b;
  logic [33:0] mul_p;

  logic in_ready_c;
  logic accept;

  assign in_ready_c = (state_q == IDLE) || ((state_q == OUT) && bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      LOOK: begin
        mul_a = {2'b00, f_q};
        mul_b = f_q;
      end
      FD: begin
        mul_a = fd_q;
        mul_b = f_q;
      end
      SD: begin
        mul_a = {7'b0, sd_q};
        mul_b = sq_q;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  assign mul_p = {16'b0, mul_a} * {18'b0, mul_b};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    f_d     = f_q;
    base_d  = base_q;
    fd_d    = fd_q;
    sd_d    = sd_q;
    sq_d    = sq_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    acc_d   = acc_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = bus.in_mant[22:16];
          f_d     = bus.in_mant[15:0];
          state_d = LOOK;
        end
      end
      LOOK: begin
        base_d  = bus.tbl_base;
        fd_d    = bus.tbl_fd;
        sd_d    = bus.tbl_sd;
        sq_d    = mul_p[31:16];
        state_d = FD;
      end
      FD: begin
        t1_d    = mul_p[33:15];
        // Base is zero-extended into the signed accumulator; t1 can exceed it.
        acc_d   = $signed({2'b00, base_q}) - $signed({10'b0, t1_d});
        state_d = SD;
      end
      SD: begin
        t2_d    = mul_p[26:15];
        acc_d   = acc_q + $signed({17'b0, t2_d});
        state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          if (accept) begin
            // Back-to-back: take the next operand while retiring this result.
            idx_d   = bus.in_mant[22:16];
            f_d     = bus.in_mant[15:0];
            state_d = LOOK;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      f_q     <= '0;
      base_q  <= '0;
      fd_q    <= '0;
      sd_q    <= '0;
      sq_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      f_q     <= f_d;
      base_q  <= base_d;
      fd_q    <= fd_d;
      sd_q    <= sd_d;
      sq_q    <= sq_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      acc_q   <= acc_d;
    end
  end

  // Saturate the 29-bit signed accumulator into the 27-bit unsigned result.
  // acc_q is only rewritten in FD/SD, so the value is stable while in OUT.
  logic [26:0] recip_c;

  always_comb begin
    if (acc_q[28]) begin
      recip_c = '0;
    end else if (acc_q[27]) begin
      recip_c = '1;
    end else begin
      recip_c = acc_q[26:0];
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_recip = recip_c;
  assign bus.tbl_idx   = idx_q;

endmodule

// File: tb/tb_recip_interp.sv
module tb_recip_interp;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   passes;

  recip_interp_if bus();

  recip_interp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Coefficient table model: combinational lookup from the registered index.
  logic [26:0] base_tab [128];
  logic [17:0] fd_tab   [128];
  logic [10:0] sd_tab   [128];

  assign bus.tbl_base = base_tab[bus.tbl_idx];
  assign bus.tbl_fd   = fd_tab[bus.tbl_idx];
  assign bus.tbl_sd   = sd_tab[bus.tbl_idx];

  // Reference: plain integer arithmetic of base - fd*f/2^15 + sd*(f*f/2^16)/2^15.
  function automatic logic [26:0] ref_recip(input longint base, input longint fd,
                                            input longint sd, input longint f);
    longint sq, t1, t2, acc;
    sq  = (f * f) / 65536;
    t1  = (fd * f) / 32768;
    t2  = (sd * sq) / 32768;
    acc = base - t1 + t2;
    if (acc < 0) return 27'd0;
    if (acc > 134217727) return 27'h7ffffff;
    return acc[26:0];
  endfunction

  function automatic logic [26:0] ref_for(input logic [22:0] mant);
    logic [6:0] i;
    i = mant[22:16];
    return ref_recip(longint'(base_tab[i]), longint'(fd_tab[i]),
                     longint'(sd_tab[i]), longint'(mant[15:0]));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
  endtask

  // Scoreboard
  typedef struct {
    logic [26:0] val;
    int          edge_n;
  } exp_t;

  exp_t        q[$];
  logic        head_seen;
  logic        stall_prev;
  logic [26:0] stall_val;

  initial begin
    head_seen  = 1'b0;
    stall_prev = 1'b0;
    stall_val  = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      head_seen  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
        check("stall_recip", {5'b0, bus.out_recip}, {5'b0, stall_val});
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out: got out_valid=1 recip %h want no result", bus.out_recip);
        end else begin
          if (!head_seen) begin
            check("latency", cyc - q[0].edge_n, 32'd3);
            head_seen = 1'b1;
          end
          if (bus.out_ready) begin
            check("result", {5'b0, bus.out_recip}, {5'b0, q[0].val});
            void'(q.pop_front());
            head_seen = 1'b0;
          end else begin
            check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
          end
        end
        stall_prev = !bus.out_ready;
        stall_val  = bus.out_recip;
      end else begin
        stall_prev = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e.val    = ref_for(bus.in_mant);
        e.edge_n = cyc + 1;
        q.push_back(e);
      end
    end
  end

  // Present one operand and return just after the accepting edge.
  task automatic issue(input logic [6:0] idx, input logic [15:0] f);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mant  = {idx, f};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL accept_timeout: got in_ready=0 want accept within 20 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [26:0] want);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) check(name, {5'b0, bus.out_recip}, {5'b0, want});
    else begin
      checks++;
      $display("FAIL %s_timeout: got out_valid=0 want result within 20 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit drained;
    checks = 0;
    passes = 0;
    for (int i = 0; i < 128; i++) begin
      base_tab[i] = 27'($urandom);
      fd_tab[i]   = 18'($urandom);
      sd_tab[i]   = 11'($urandom);
    end
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b1;

    rst = 1'b1;
    #1;
    check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_tbl_idx",   {25'b0, bus.tbl_idx},   32'd0);
    check("rst_out_recip", {5'b0, bus.out_recip},  32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Exact table hit (f=0)
    base_tab[127] = 27'h0040404; fd_tab[127] = 18'h10202; sd_tab[127] = 11'h101;
    issue(7'h7f, 16'h0000);
    wait_out("f_zero", 27'h0040404);

    // Mid-interval interpolation
    base_tab[0] = 27'h3fffffe; fd_tab[0] = 18'h3fff7; sd_tab[0] = 11'h7e8;
    issue(7'h00, 16'h8000);
    wait_out("mid", 27'h3fc03fb);

    // Clamp low
    base_tab[1] = 27'h0; fd_tab[1] = 18'h3ffff; sd_tab[1] = 11'h0;
    issue(7'h01, 16'hffff);
    wait_out("clamp_low", 27'h0);

    // Clamp high
    base_tab[2] = 27'h7ffffff; fd_tab[2] = 18'h0; sd_tab[2] = 11'h7ff;
    issue(7'h02, 16'hffff);
    wait_out("clamp_high", 27'h7ffffff);

    // Backpressure then back-to-back accept out of OUT
    bus.out_ready = 1'b0;
    issue(7'h00, 16'h8000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    repeat (5) @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.in_mant   = {7'h01, 16'hffff};
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_out("b2b_second", 27'h0);

    // Reset while in FD: in-flight result must vanish
    issue(7'h02, 16'hffff);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("abort_in_ready",  {31'b0, bus.in_ready},  32'd1);
    check("abort_tbl_idx",   {25'b0, bus.tbl_idx},   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(7'h00, 16'h8000);
    wait_out("after_abort", 27'h3fc03fb);

    // Random operands, random valid/ready; in_valid while busy must be ignored
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_mant   = 23'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.out_valid) begin
        drained = 1'b1;
        break;
      end
    end
    check("drain", {31'b0, drained}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
